pipe_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the hold and flush inputs of every pipeline register: PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Collects hazard requests from ID (load-use), EX (multi-cycle divide) and MEM (data-memory wait), plus exceptions.
- Times the multi-cycle events internally with a state machine and counters, then emits a per-stage stall vector, a flush pulse and the redirect PC.

---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates load-use, divide, data-memory wait and exception requests.
// Times multi-cycle divides and memory waits with a small FSM.
// Drives the per-stage hold vector, a one-cycle flush with redirect PC, and bus-error pulses.
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES  = 8,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idStallReq,
    input  logic        exDivStart,
    input  logic        memReq,
    input  logic        memAck,
    input  logic        excReq,
    input  logic [31:0] excVector,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] newPC,
    output logic        divDone,
    output logic        busErr,
    output logic [31:0] stallCount
);

    typedef enum logic [1:0] {StRun, StDiv, StMem} state_e;

    localparam logic [7:0] DivInit    = 8'(DIV_CYCLES - 1);
    localparam logic [7:0] MemTimeout = 8'(MEM_TIMEOUT);

    localparam logic [5:0] StallId  = 6'b000111;
    localparam logic [5:0] StallEx  = 6'b001111;
    localparam logic [5:0] StallMem = 6'b011111;

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_timer;
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic        r_bus_err;
    logic [31:0] r_stall_count;

    state_e      w_state_d;
    logic [7:0]  w_cnt_d;
    logic [7:0]  w_timer_d;
    logic [5:0]  w_stall;
    logic        w_div_done;
    logic        w_flush_d;
    logic        w_bus_err_d;

    // Next-state, stall vector and divide-done decode; nothing is sampled during a flush cycle.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_timer_d   = r_timer;
        w_stall     = 6'b000000;
        w_div_done  = 1'b0;
        w_flush_d   = 1'b0;
        w_bus_err_d = 1'b0;
        if (!r_flush) begin
            case (r_state)
                StRun: begin
                    if (excReq) begin
                        w_flush_d = 1'b1;
                    end else if (memReq) begin
                        if (!memAck) begin
                            w_stall   = StallMem;
                            w_state_d = StMem;
                            w_timer_d = 8'd1;
                        end
                    end else if (exDivStart) begin
                        w_stall   = StallEx;
                        w_state_d = StDiv;
                        w_cnt_d   = DivInit;
                    end else if (idStallReq) begin
                        w_stall = StallId;
                    end
                end
                StDiv: begin
                    if (excReq) begin
                        // Abort the divide: no divDone for it.
                        w_flush_d = 1'b1;
                        w_state_d = StRun;
                    end else if (r_cnt != 8'd1) begin
                        w_stall = StallEx;
                        w_cnt_d = r_cnt - 8'd1;
                    end else begin
                        w_div_done = 1'b1;
                        w_state_d  = StRun;
                    end
                end
                StMem: begin
                    if (excReq) begin
                        w_flush_d = 1'b1;
                        w_state_d = StRun;
                    end else if (memAck) begin
                        // An ack in the timeout cycle still wins over the bus error.
                        w_state_d = StRun;
                    end else if (r_timer < MemTimeout) begin
                        w_stall   = StallMem;
                        w_timer_d = r_timer + 8'd1;
                    end else begin
                        w_flush_d   = 1'b1;
                        w_bus_err_d = 1'b1;
                        w_state_d   = StRun;
                    end
                end
                default: w_state_d = StRun;
            endcase
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign stall      = rst ? w_stall : 6'b000000;
    assign divDone    = rst ? w_div_done : 1'b0;
    assign flush      = r_flush;
    assign newPC      = r_new_pc;
    assign busErr     = r_bus_err;
    assign stallCount = r_stall_count;

    // FSM state, timers, registered flush/redirect/bus-error and the saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StRun;
            r_cnt         <= 8'd0;
            r_timer       <= 8'd0;
            r_flush       <= 1'b0;
            r_new_pc      <= 32'h0;
            r_bus_err     <= 1'b0;
            r_stall_count <= 32'h0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_timer   <= w_timer_d;
            r_flush   <= w_flush_d;
            r_new_pc  <= w_flush_d ? excVector : 32'h0;
            r_bus_err <= w_bus_err_d;
            if ((w_stall != 6'b000000) && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

endmodule
